id_front: RTL and testbench

Instruction-decode front end of the summer CPU pipeline, directly upstream of the ID/EX pipeline register. Holds the IF/ID pipeline latch and the 32×32 general-purpose register file with write-through bypass. Detects load-use hazards and ID-stage jumps. Produces the register operands, instruction fields and the `Stall` signal that the ID/EX register consumes; `Stall` zeroes the ID/EX register.

---
 rtl/id_front.sv | 135 +++++++++++++
 tb/tb_id_front.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_front.sv
// Instruction-decode front end: IF/ID latch, 32x32 register file with WB bypass,
// load-use stall and ID-stage jump detection feeding the ID/EX register.
module id_front (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IF_PC4,
  input  logic [31:0] IF_Instr,
  input  logic        Flush,
  input  logic        EX_MemRd,
  input  logic [4:0]  EX_AddrC,
  input  logic        WB_RegWr,
  input  logic [4:0]  WB_AddrC,
  input  logic [31:0] WB_Data,
  output logic [31:0] ID_PC4,
  output logic [31:0] ID_Instr,
  output logic        ID_Valid,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [31:0] DataBusA,
  output logic [31:0] DataBusB,
  output logic        Stall,
  output logic        JumpFlush
);

  localparam int DATA_W = 32;
  localparam int NREG   = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] pc4_q, pc4_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;

  logic              wb_we;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic              is_jump;
  logic              load_use;

  assign wb_we = WB_RegWr && (WB_AddrC != 5'd0);

  // Read port with write-through: a same-cycle WB write to the index wins over
  // the array contents; $0 never bypasses and always reads zero.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [4:0]        idx,
    input logic              we,
    input logic [4:0]        waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    val = stored;
    if (idx == 5'd0)
      val = '0;
    else if (we && (waddr == idx))
      val = wdata;
    return val;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++)
        rf_q[i] <= '0;
    end else if (wb_we) begin
      rf_q[WB_AddrC] <= WB_Data;
    end
  end

  assign Rs     = instr_q[25:21];
  assign Rt     = instr_q[20:16];
  assign Rd     = instr_q[15:11];
  assign opcode = instr_q[31:26];
  assign funct  = instr_q[5:0];

  assign DataBusA = read_port(Rs, wb_we, WB_AddrC, WB_Data, rf_q[Rs]);
  assign DataBusB = read_port(Rt, wb_we, WB_AddrC, WB_Data, rf_q[Rt]);

  // A load in EX whose destination feeds either source of the ID instruction.
  assign load_use = valid_q && EX_MemRd && (EX_AddrC != 5'd0) &&
                    ((EX_AddrC == Rs) || (EX_AddrC == Rt));

  assign is_jump = (opcode == OP_J) || (opcode == OP_JAL) ||
                   ((opcode == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR)));

  assign Stall     = load_use;
  assign JumpFlush = valid_q && !load_use && is_jump;

  // Stall holds a JR/JALR until its operand is ready; Flush beats everything
  // because the stalled instruction is on the wrong path.
  always_comb begin
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (Flush) begin
      pc4_d   = '0;
      instr_d = '0;
      valid_d = 1'b0;
    end else if (load_use) begin
      pc4_d   = pc4_q;
      instr_d = instr_q;
      valid_d = valid_q;
    end else if (JumpFlush) begin
      pc4_d   = '0;
      instr_d = '0;
      valid_d = 1'b0;
    end else begin
      pc4_d   = IF_PC4;
      instr_d = IF_Instr;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc4_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign ID_PC4   = pc4_q;
  assign ID_Instr = instr_q;
  assign ID_Valid = valid_q;

endmodule

// File: tb/tb_id_front.sv
// Bench for id_front: directed scenarios plus randomized traffic against a
// behavioural model of the IF/ID latch, register file and hazard rules.
module tb_id_front;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IF_PC4, IF_Instr;
  logic        Flush, EX_MemRd;
  logic [4:0]  EX_AddrC;
  logic        WB_RegWr;
  logic [4:0]  WB_AddrC;
  logic [31:0] WB_Data;
  logic [31:0] ID_PC4, ID_Instr;
  logic        ID_Valid;
  logic [4:0]  Rs, Rt, Rd;
  logic [31:0] DataBusA, DataBusB;
  logic        Stall, JumpFlush;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_rf [32];
  logic [31:0] m_pc4, m_instr;
  logic        m_valid;

  always #5 clk = ~clk;

  id_front dut (
    .clk(clk), .reset(reset), .IF_PC4(IF_PC4), .IF_Instr(IF_Instr),
    .Flush(Flush), .EX_MemRd(EX_MemRd), .EX_AddrC(EX_AddrC),
    .WB_RegWr(WB_RegWr), .WB_AddrC(WB_AddrC), .WB_Data(WB_Data),
    .ID_PC4(ID_PC4), .ID_Instr(ID_Instr), .ID_Valid(ID_Valid),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .DataBusA(DataBusA), .DataBusB(DataBusB),
    .Stall(Stall), .JumpFlush(JumpFlush)
  );

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
    logic [4:0] a, b, c;
    logic [5:0] f;
    a = rs[4:0]; b = rt[4:0]; c = rd[4:0]; f = fn[5:0];
    return {6'h00, a, b, c, 5'd0, f};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (WB_RegWr && WB_AddrC == idx) return WB_Data;
    return m_rf[idx];
  endfunction

  function automatic logic m_stall();
    return m_valid && EX_MemRd && (EX_AddrC != 5'd0) &&
           (EX_AddrC == m_instr[25:21] || EX_AddrC == m_instr[20:16]);
  endfunction

  function automatic logic m_jump();
    logic [5:0] op, fn;
    op = m_instr[31:26];
    fn = m_instr[5:0];
    return m_valid && !m_stall() &&
           (op == 6'h02 || op == 6'h03 || (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_pc4 = 0; m_instr = 0; m_valid = 0;
  endtask

  task automatic clear_inputs();
    IF_PC4 = 0; IF_Instr = 0; Flush = 0; EX_MemRd = 0; EX_AddrC = 0;
    WB_RegWr = 0; WB_AddrC = 0; WB_Data = 0;
  endtask

  // One clock: compute model next state from the stable inputs, then advance.
  task automatic tick();
    logic [31:0] n_pc4, n_instr;
    logic        n_valid;
    if (Flush) begin
      n_pc4 = 0; n_instr = 0; n_valid = 0;
    end else if (m_stall()) begin
      n_pc4 = m_pc4; n_instr = m_instr; n_valid = m_valid;
    end else if (m_jump()) begin
      n_pc4 = 0; n_instr = 0; n_valid = 0;
    end else begin
      n_pc4 = IF_PC4; n_instr = IF_Instr; n_valid = 1;
    end
    @(posedge clk);
    if (WB_RegWr && WB_AddrC != 0) m_rf[WB_AddrC] = WB_Data;
    m_pc4 = n_pc4; m_instr = n_instr; m_valid = n_valid;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    checks++; if (ID_Instr !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h want=0", ID_Instr); end
    checks++; if (ID_PC4 !== 32'd0) begin failures++; $display("FAIL reset_pc4 got=%h want=0", ID_PC4); end
    checks++; if (ID_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", ID_Valid); end
    checks++; if ({Stall, JumpFlush} !== 2'b00) begin failures++; $display("FAIL reset_hazard got=%b want=00", {Stall, JumpFlush}); end
    checks++; if ({DataBusA, DataBusB} !== 64'd0) begin failures++; $display("FAIL reset_bus got=%h want=0", {DataBusA, DataBusB}); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    WB_RegWr = 1; WB_AddrC = 5; WB_Data = 32'hDEADBEEF;
    tick();
    WB_RegWr = 0; IF_Instr = rtype(5, 0, 3, 6'h20); IF_PC4 = 32'h0000_0104;
    tick();
    IF_Instr = 0;
    #1;
    checks++; if (Rs !== 5'd5) begin failures++; $display("FAIL wr_rs got=%0d want=5", Rs); end
    checks++; if (DataBusA !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_busA got=%h want=deadbeef", DataBusA); end
    checks++; if (DataBusB !== 32'd0) begin failures++; $display("FAIL wr_busB got=%h want=0", DataBusB); end
    checks++; if (ID_PC4 !== 32'h0000_0104 || ID_Valid !== 1'b1) begin failures++; $display("FAIL wr_latch got=%h/%b want=00000104/1", ID_PC4, ID_Valid); end
    tick();
  endtask

  task automatic test_bypass();
    IF_Instr = rtype(7, 0, 1, 6'h20);
    tick();
    IF_Instr = 0;
    WB_RegWr = 1; WB_AddrC = 7; WB_Data = 32'h12345678;
    #1;
    checks++; if (DataBusA !== 32'h12345678) begin failures++; $display("FAIL bypass_busA got=%h want=12345678", DataBusA); end
    WB_AddrC = 0; WB_Data = 32'hFFFFFFFF;
    #1;
    checks++; if (DataBusB !== 32'd0) begin failures++; $display("FAIL zero_bypass got=%h want=0", DataBusB); end
    tick();
    WB_RegWr = 0;
    IF_Instr = rtype(0, 7, 2, 6'h20);
    tick();
    IF_Instr = 0;
    #1;
    checks++; if (DataBusA !== 32'd0) begin failures++; $display("FAIL zero_read got=%h want=0", DataBusA); end
    checks++; if (DataBusB !== 32'd0) begin failures++; $display("FAIL r7_unwritten got=%h want=0", DataBusB); end
    tick();
  endtask

  task automatic test_load_use();
    logic [31:0] ins;
    ins = rtype(2, 6, 4, 6'h20);
    IF_Instr = ins; IF_PC4 = 32'h40;
    tick();
    IF_Instr = 32'h2001_0005; IF_PC4 = 32'h44;
    EX_MemRd = 1; EX_AddrC = 2;
    #1;
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b want=1", Stall); end
    tick();
    EX_MemRd = 0;
    #1;
    checks++; if (ID_Instr !== ins || ID_PC4 !== 32'h40) begin failures++; $display("FAIL lu_hold got=%h/%h want=%h/00000040", ID_Instr, ID_PC4, ins); end
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL lu_release got=%b want=0", Stall); end
    EX_MemRd = 1; EX_AddrC = 6;
    #1;
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL lu_rt got=%b want=1", Stall); end
    EX_MemRd = 0;
    IF_Instr = rtype(0, 6, 4, 6'h20);
    tick();
    EX_MemRd = 1; EX_AddrC = 0;
    #1;
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL lu_zero got=%b want=0", Stall); end
    clear_inputs();
    tick();
  endtask

  task automatic test_flush_stall();
    IF_Instr = rtype(2, 6, 4, 6'h20); IF_PC4 = 32'h80;
    tick();
    IF_Instr = 32'h1111_2222;
    EX_MemRd = 1; EX_AddrC = 2; Flush = 1;
    #1;
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL fs_stall got=%b want=1", Stall); end
    tick();
    Flush = 0;
    #1;
    checks++; if (ID_Instr !== 32'd0 || ID_Valid !== 1'b0) begin failures++; $display("FAIL fs_nop got=%h/%b want=0/0", ID_Instr, ID_Valid); end
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL fs_stall_drop got=%b want=0", Stall); end
    clear_inputs();
    tick();
  endtask

  task automatic test_jump();
    logic [31:0] jr;
    IF_Instr = {6'h02, 26'h40}; IF_PC4 = 32'hC0;
    tick();
    IF_Instr = 32'h0123_4567; IF_PC4 = 32'hC4;
    #1;
    checks++; if (JumpFlush !== 1'b1) begin failures++; $display("FAIL j_flush got=%b want=1", JumpFlush); end
    tick();
    #1;
    checks++; if (ID_Instr !== 32'd0 || ID_Valid !== 1'b0) begin failures++; $display("FAIL j_nop got=%h/%b want=0/0", ID_Instr, ID_Valid); end
    jr = rtype(9, 0, 0, 6'h08);
    IF_Instr = jr;
    tick();
    IF_Instr = 32'h0123_4567;
    EX_MemRd = 1; EX_AddrC = 9;
    #1;
    checks++; if (Stall !== 1'b1 || JumpFlush !== 1'b0) begin failures++; $display("FAIL jr_c1 got=%b%b want=10", Stall, JumpFlush); end
    tick();
    EX_MemRd = 0;
    #1;
    checks++; if (JumpFlush !== 1'b1 || ID_Instr !== jr) begin failures++; $display("FAIL jr_c2 got=%b/%h want=1/%h", JumpFlush, ID_Instr, jr); end
    tick();
    #1;
    checks++; if (ID_Instr !== 32'd0) begin failures++; $display("FAIL jr_nop got=%h want=0", ID_Instr); end
    clear_inputs();
    tick();
  endtask

  task automatic test_async_reset();
    WB_RegWr = 1; WB_AddrC = 3; WB_Data = 32'hCAFE0001;
    tick();
    WB_RegWr = 0;
    IF_Instr = rtype(3, 3, 1, 6'h20); IF_PC4 = 32'h200;
    tick();
    EX_MemRd = 1; EX_AddrC = 3;
    #1;
    checks++; if (Stall !== 1'b1 || ID_Valid !== 1'b1 || DataBusA !== 32'hCAFE0001) begin failures++; $display("FAIL ar_pre got=%b%b/%h want=11/cafe0001", Stall, ID_Valid, DataBusA); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({ID_Instr, ID_PC4, ID_Valid, Stall, JumpFlush} !== 67'd0) begin failures++; $display("FAIL ar_state got=%h/%h/%b%b%b want=0", ID_Instr, ID_PC4, ID_Valid, Stall, JumpFlush); end
    checks++; if ({DataBusA, DataBusB} !== 64'd0) begin failures++; $display("FAIL ar_bus got=%h want=0", {DataBusA, DataBusB}); end
    model_reset();
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    IF_Instr = rtype(3, 0, 1, 6'h20);
    tick();
    #1;
    checks++; if (DataBusA !== 32'd0) begin failures++; $display("FAIL ar_rf_clear got=%h want=0", DataBusA); end
  endtask

  task automatic test_random();
    logic [5:0]  op;
    logic [4:0]  ra, rb;
    logic [31:0] r;
    for (int n = 0; n < 500; n++) begin
      Flush    = ($urandom_range(0, 7) == 0);
      EX_MemRd = ($urandom_range(0, 2) == 0);
      EX_AddrC = 5'($urandom_range(0, 7));
      WB_RegWr = ($urandom_range(0, 1) == 1);
      WB_AddrC = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      WB_Data  = $urandom;
      IF_PC4   = $urandom;
      r  = $urandom;
      ra = 5'($urandom_range(0, 7));
      rb = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: op = 6'h02;
        1: op = 6'h03;
        2: op = 6'h00;
        3: op = 6'h00;
        4: op = 6'h23;
        default: op = 6'(r[31:26]);
      endcase
      IF_Instr = {op, ra, rb, r[15:0]};
      if (op == 6'h00 && r[16]) IF_Instr[5:0] = r[17] ? 6'h09 : 6'h08;
      #1;
      checks++; if (ID_Instr !== m_instr || ID_PC4 !== m_pc4 || ID_Valid !== m_valid) begin failures++; $display("FAIL rnd_latch n=%0d got=%h/%h/%b want=%h/%h/%b", n, ID_Instr, ID_PC4, ID_Valid, m_instr, m_pc4, m_valid); end
      checks++; if ({Rs, Rt, Rd} !== {m_instr[25:21], m_instr[20:16], m_instr[15:11]}) begin failures++; $display("FAIL rnd_fields n=%0d got=%h want=%h", n, {Rs, Rt, Rd}, {m_instr[25:21], m_instr[20:16], m_instr[15:11]}); end
      checks++; if (Stall !== m_stall() || JumpFlush !== m_jump()) begin failures++; $display("FAIL rnd_hazard n=%0d got=%b%b want=%b%b", n, Stall, JumpFlush, m_stall(), m_jump()); end
      checks++; if (DataBusA !== m_read(m_instr[25:21]) || DataBusB !== m_read(m_instr[20:16])) begin failures++; $display("FAIL rnd_bus n=%0d got=%h/%h want=%h/%h", n, DataBusA, DataBusB, m_read(m_instr[25:21]), m_read(m_instr[20:16])); end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_bypass();
    test_load_use();
    test_flush_stall();
    test_jump();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
